// File: rtl/reduction_pkg.sv
// Shared widths, mode encodings and S1 payload layout for the lane-sum
// reduction unit.
//   clog2   : ceiling log2 of a positive integer (clog2(1) = 0)
//   sum_w   : exact width of one beat's 2*lanes lane sum
//   MODE_*  : value of in_signed for each lane interpretation
//   S1_F_*  : bit positions of the per-beat flags held in stage 1
package reduction_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int sum_w(input int lane_w, input int lanes);
      return lane_w + clog2(2 * lanes);
   endfunction

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   localparam int S1_F_SIGNED = 0;
   localparam int S1_F_ACC    = 1;
   localparam int S1_F_W      = 2;

endpackage

// File: rtl/lane_tree_adder.sv
// Combinational balanced adder tree summing N lanes of LANE_W bits.
// Each level widens its operands by one bit (sign- or zero-extended by
// in_signed), so the root is exactly LANE_W+clog2(N) bits and never wraps.
//   in_signed : MODE_SIGNED treats lanes as two's complement
//   lanes     : lane k = lanes[k*LANE_W +: LANE_W]
//   sum       : exact sum of all lanes
module lane_tree_adder
   import reduction_pkg::*;
#(
   parameter int LANE_W = 4,
   parameter int N      = 8
) (
   input  logic                          in_signed,
   input  logic [N*LANE_W-1:0]           lanes,
   output logic [LANE_W+clog2(N)-1:0]    sum
);

   localparam int LV = clog2(N);
   localparam int NP = 1 << LV;

   logic sx;
   assign sx = (in_signed == MODE_SIGNED);

   // Leaves beyond N (non power-of-two N) are zero and do not disturb the sum.
   for (genvar l = 0; l <= LV; l++) begin : lvl
      localparam int W   = LANE_W + l;
      localparam int CNT = NP >> l;
      logic [CNT*W-1:0] s;
      if (l == 0) begin : g_leaf
         for (genvar k = 0; k < CNT; k++) begin : g_node
            if (k < N) begin : g_lane
               assign s[k*W +: W] = lanes[k*LANE_W +: LANE_W];
            end else begin : g_pad
               assign s[k*W +: W] = '0;
            end
         end
      end else begin : g_add
         for (genvar k = 0; k < CNT; k++) begin : g_node
            logic [W-2:0] a;
            logic [W-2:0] b;
            assign a = lvl[l-1].s[(2*k)*(W-1) +: (W-1)];
            assign b = lvl[l-1].s[(2*k+1)*(W-1) +: (W-1)];
            assign s[k*W +: W] = {sx & a[W-2], a} + {sx & b[W-2], b};
         end
      end
   end

   assign sum = lvl[LV].s;

endmodule

// File: rtl/pipelined_reduction_unit.sv
// Two-stage pipelined lane-sum reduction with optional accumulation.
// S1 registers the exact tree sum of both operands' lanes plus mode flags;
// S2 extends it to OUT_W, optionally adds the running total, and presents it.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_rs, in_rt          : operands, LANES lanes of LANE_W bits each
//   in_signed, in_acc     : per-beat lane signedness / accumulate select
//   out_valid/out_ready   : output handshake
//   out_rd                : OUT_W result
//   out_ovf               : accumulate add overflowed OUT_W
module pipelined_reduction_unit
   import reduction_pkg::*;
#(
   parameter int LANE_W = 4,
   parameter int LANES  = 4,
   parameter int OUT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANE_W*LANES-1:0]   in_rs,
   input  logic [LANE_W*LANES-1:0]   in_rt,
   input  logic                      in_signed,
   input  logic                      in_acc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_W-1:0]          out_rd,
   output logic                      out_ovf
);

   localparam int N     = 2 * LANES;
   localparam int SUM_W = sum_w(LANE_W, LANES);

   if (OUT_W < SUM_W) begin : g_bad_out_w
      $error("pipelined_reduction_unit: OUT_W must be >= SUM_W");
   end

   logic [SUM_W-1:0]  tree_sum;
   logic              v1;
   logic              v2;
   logic [SUM_W-1:0]  s1_sum;
   logic [S1_F_W-1:0] s1_flags;
   logic [OUT_W-1:0]  acc;
   logic [OUT_W-1:0]  rd_q;
   logic              ovf_q;
   logic              s2_free;
   logic              s1_adv;
   logic              accept;
   logic [OUT_W-1:0]  ext;
   logic [OUT_W:0]    add_full;
   logic [OUT_W-1:0]  res;
   logic              ovf;

   lane_tree_adder #(
      .LANE_W (LANE_W),
      .N      (N)
   ) u_tree (
      .in_signed (in_signed),
      .lanes     ({in_rt, in_rs}),
      .sum       (tree_sum)
   );

   assign s2_free = !v2 || out_ready;
   assign s1_adv  = v1 && s2_free;
   // Held low during reset so nothing is offered acceptance while flushing.
   assign in_ready = !rst && (!v1 || s2_free);
   assign accept   = in_valid && in_ready;

   always_comb begin
      ext = OUT_W'(s1_sum);
      if (s1_flags[S1_F_SIGNED] == MODE_SIGNED) ext = OUT_W'($signed(s1_sum));
      add_full = {1'b0, acc} + {1'b0, ext};
      res      = ext;
      ovf      = 1'b0;
      if (s1_flags[S1_F_ACC]) begin
         res = add_full[OUT_W-1:0];
         if (s1_flags[S1_F_SIGNED] == MODE_SIGNED)
            ovf = (acc[OUT_W-1] == ext[OUT_W-1]) && (add_full[OUT_W-1] != acc[OUT_W-1]);
         else
            ovf = add_full[OUT_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1       <= 1'b0;
         s1_sum   <= '0;
         s1_flags <= '0;
      end else begin
         if (accept) begin
            v1                    <= 1'b1;
            s1_sum                <= tree_sum;
            s1_flags[S1_F_SIGNED] <= in_signed;
            s1_flags[S1_F_ACC]    <= in_acc;
         end else if (s1_adv) begin
            v1 <= 1'b0;
         end
      end
   end

   // Every beat reloads acc, so a non-accumulate beat starts a fresh chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2    <= 1'b0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
         acc   <= '0;
      end else begin
         if (s1_adv) begin
            v2    <= 1'b1;
            rd_q  <= res;
            ovf_q <= ovf;
            acc   <= res;
         end else if (out_ready) begin
            v2 <= 1'b0;
         end
      end
   end

   assign out_valid = v2;
   assign out_rd    = rd_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_reduction_unit.sv
module tb_pipelined_reduction_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_signed = 1'b0;
   logic        in_acc = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] in_rs = '0;
   logic [15:0] in_rt = '0;

   logic        rdy_a, val_a, ovf_a;
   logic [15:0] rd_a;
   logic        rdy_b, val_b, ovf_b;
   logic [7:0]  rd_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipelined_reduction_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
      .in_rs(in_rs), .in_rt(in_rt), .in_signed(in_signed), .in_acc(in_acc),
      .out_valid(val_a), .out_ready(out_ready), .out_rd(rd_a), .out_ovf(ovf_a)
   );

   pipelined_reduction_unit #(.OUT_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
      .in_rs(in_rs), .in_rt(in_rt), .in_signed(in_signed), .in_acc(in_acc),
      .out_valid(val_b), .out_ready(out_ready), .out_rd(rd_b), .out_ovf(ovf_b)
   );

   task automatic drive(input logic [15:0] rs, input logic [15:0] rt, input logic sg, input logic ac);
      in_rs = rs; in_rt = rt; in_signed = sg; in_acc = ac; in_valid = 1'b1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", val_a); end
      checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL rst_rd: got %h expected 0000", rd_a); end
      checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf_a); end
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b expected 0", rdy_a); end
      checks++; if (val_b !== 1'b0 || rd_b !== 8'h00) begin errors++; $display("FAIL rst_w8: got valid=%b rd=%h expected 0/00", val_b, rd_b); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b expected 1", rdy_a); end
   endtask

   task automatic test_unsigned_max();
      drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      #1;
      checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL umax_ready: got %b expected 1", rdy_a); end
      tick();
      idle();
      checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL umax_lat1: got valid=%b expected 0", val_a); end
      tick();
      checks++; if (val_a !== 1'b1) begin errors++; $display("FAIL umax_lat2: got valid=%b expected 1", val_a); end
      checks++; if (rd_a !== 16'h0078) begin errors++; $display("FAIL umax_rd: got %h expected 0078", rd_a); end
      checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL umax_ovf: got %b expected 0", ovf_a); end
      tick();
      checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL umax_drain: got valid=%b expected 0", val_a); end
   endtask

   task automatic test_signed();
      logic [15:0] rs [2] = '{16'h8888, 16'h1234};
      logic [15:0] rt [2] = '{16'h8888, 16'hF0F0};
      logic [15:0] ex [2] = '{16'hFFC0, 16'h0008};
      for (int i = 0; i <= 2; i++) begin
         if (i < 2) drive(rs[i], rt[i], 1'b1, 1'b0); else idle();
         tick();
         if (i >= 1) begin
            checks++; if (val_a !== 1'b1 || rd_a !== ex[i-1] || ovf_a !== 1'b0)
               begin errors++; $display("FAIL signed_%0d: got valid=%b rd=%h ovf=%b expected 1/%h/0", i-1, val_a, rd_a, ovf_a, ex[i-1]); end
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] rs [3] = '{16'hFFFF, 16'hFFFF, 16'h0001};
      logic [15:0] rt [3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
      logic        ac [3] = '{1'b0, 1'b1, 1'b0};
      logic [15:0] ex [3] = '{16'h0078, 16'h00F0, 16'h0001};
      for (int i = 0; i <= 3; i++) begin
         if (i < 3) drive(rs[i], rt[i], 1'b0, ac[i]); else idle();
         tick();
         if (i >= 1) begin
            checks++; if (val_a !== 1'b1 || rd_a !== ex[i-1] || ovf_a !== 1'b0)
               begin errors++; $display("FAIL chain_%0d: got valid=%b rd=%h ovf=%b expected 1/%h/0", i-1, val_a, rd_a, ovf_a, ex[i-1]); end
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [15:0] rs [4] = '{16'hFFFF, 16'h1111, 16'h0001, 16'h2222};
      logic [15:0] rt [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h2222};
      logic        ac [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] ex [4] = '{16'h0078, 16'h007C, 16'h0001, 16'h0011};
      int idx = 0;
      int outs = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (idx < 4) drive(rs[idx], rt[idx], 1'b0, ac[idx]); else idle();
         #1;
         if (in_valid && rdy_a) idx++;
         tick();
      end
      checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", rdy_a); end
      checks++; if (val_a !== 1'b1 || rd_a !== 16'h0078) begin errors++; $display("FAIL bp_hold: got valid=%b rd=%h expected 1/0078", val_a, rd_a); end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && outs < 4; c++) begin
         if (idx < 4) drive(rs[idx], rt[idx], 1'b0, ac[idx]); else idle();
         #1;
         if (val_a && out_ready) begin
            checks++; if (rd_a !== ex[outs]) begin errors++; $display("FAIL bp_out_%0d: got %h expected %h", outs, rd_a, ex[outs]); end
            outs++;
         end
         if (in_valid && rdy_a) idx++;
         tick();
      end
      idle();
      checks++; if (outs !== 4) begin errors++; $display("FAIL bp_count: got %0d results expected 4", outs); end
      tick();
   endtask

   task automatic test_overflow();
      logic [7:0] ex_u [3] = '{8'h78, 8'hF0, 8'h68};
      logic       ov_u [3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0] ex_s [3] = '{8'h38, 8'h70, 8'hA8};
      logic       ov_s [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i <= 3; i++) begin
         if (i < 3) drive(16'hFFFF, 16'hFFFF, 1'b0, (i != 0)); else idle();
         tick();
         if (i >= 1) begin
            checks++; if (val_b !== 1'b1 || rd_b !== ex_u[i-1] || ovf_b !== ov_u[i-1])
               begin errors++; $display("FAIL ovf_u_%0d: got valid=%b rd=%h ovf=%b expected 1/%h/%b", i-1, val_b, rd_b, ovf_b, ex_u[i-1], ov_u[i-1]); end
         end
      end
      pulse_reset();
      for (int i = 0; i <= 3; i++) begin
         if (i < 3) drive(16'h7777, 16'h7777, 1'b1, 1'b1); else idle();
         tick();
         if (i >= 1) begin
            checks++; if (val_b !== 1'b1 || rd_b !== ex_s[i-1] || ovf_b !== ov_s[i-1])
               begin errors++; $display("FAIL ovf_s_%0d: got valid=%b rd=%h ovf=%b expected 1/%h/%b", i-1, val_b, rd_b, ovf_b, ex_s[i-1], ov_s[i-1]); end
            checks++; if (rd_a !== {8'h00, ex_s[i-1]} || ovf_a !== 1'b0)
               begin errors++; $display("FAIL ovf_s16_%0d: got rd=%h ovf=%b expected %h/0", i-1, rd_a, ovf_a, {8'h00, ex_s[i-1]}); end
         end
      end
      tick();
   endtask

   task automatic test_mid_reset();
      drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      tick();
      drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++; if (val_a !== 1'b0 || rd_a !== 16'h0000 || ovf_a !== 1'b0)
         begin errors++; $display("FAIL mid_rst_out: got valid=%b rd=%h ovf=%b expected 0/0000/0", val_a, rd_a, ovf_a); end
      checks++; if (rdy_a !== 1'b0 || val_b !== 1'b0) begin errors++; $display("FAIL mid_rst_hs: got ready=%b valid8=%b expected 0/0", rdy_a, val_b); end
      @(negedge clk);
      rst = 1'b0;
      drive(16'h0001, 16'h0000, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      checks++; if (val_a !== 1'b1 || rd_a !== 16'h0001 || ovf_a !== 1'b0)
         begin errors++; $display("FAIL mid_rst_acc: got valid=%b rd=%h ovf=%b expected 1/0001/0", val_a, rd_a, ovf_a); end
      checks++; if (rd_b !== 8'h01) begin errors++; $display("FAIL mid_rst_acc8: got %h expected 01", rd_b); end
      tick();
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_signed();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
